pt_walker: RTL and testbench

- Two-level hardware page-table walker. It is the initiator on the memory req/resp interface, where the memory block is the responder.
- It accepts a virtual-address walk request from the TLB, issues up to two PTE reads to memory, and returns a translated PPN, flags, or a fault.
- It sits between the TLB miss path and the shared memory port.

---
 rtl/pt_walker_pkg.sv | 29 ++
 rtl/pt_walker_pte_check.sv | 32 +++
 rtl/pt_walker.sv | 118 +++++++++++
 tb/tb_pt_walker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pt_walker_pkg.sv
// Shared types and constants for the two-level page-table walker.
// PTE layout: bit0 V, bit1 R, bit2 W, bit3 X; next-level base in pte[31:10].
package pt_walker_pkg;

    localparam int VPN_W  = 10;
    localparam int OFF_W  = 12;
    localparam int PPN_W  = 20;
    localparam int FLAG_W = 4;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;

    typedef enum logic [2:0] {
        IDLE,
        L1_REQ,
        L1_WAIT,
        L2_REQ,
        L2_WAIT,
        RESP
    } state_t;

    // Any of R/W/X set marks a leaf; all clear points at the next table.
    function automatic logic pte_is_leaf(input logic [31:0] pte);
        return pte[PTE_R] | pte[PTE_W] | pte[PTE_X];
    endfunction

endpackage

// File: rtl/pt_walker_pte_check.sv
// Combinational PTE decode shared by both walk levels: leaf/fault detection
// and the resulting PPN (zero whenever the PTE faults).
module pt_walker_pte_check
    import pt_walker_pkg::*;
(
    input  logic [31:0]      pte,
    input  logic             level2,
    input  logic [VPN_W-1:0] vpn0,
    output logic             leaf,
    output logic             fault,
    output logic [PPN_W-1:0] ppn
);

    logic reserved;
    logic misaligned;
    logic unused_pte_bits;

    assign unused_pte_bits = ^pte[11:4];

    always_comb begin
        leaf       = pte_is_leaf(pte);
        reserved   = pte[PTE_W] & ~pte[PTE_R];
        misaligned = leaf & (pte[21:12] != '0);
        // Level 2 must end in a leaf; level 1 leaves must be 4 MiB aligned.
        fault      = ~pte[PTE_V] | reserved | (level2 ? ~leaf : misaligned);
        ppn        = '0;
        if (!fault && leaf) begin
            ppn = level2 ? pte[31:12] : {pte[31:22], vpn0};
        end
    end

endmodule

// File: rtl/pt_walker.sv
// Two-level page-table walker: takes a VA from the TLB, reads up to two PTEs
// over a valid/ready memory port and returns PPN, flags or a page fault.
module pt_walker
    import pt_walker_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] ROOT_BASE = 32'h0000_0400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              walk_req_valid_i,
    output logic              walk_req_ready_o,
    input  logic [ADDR_W-1:0] walk_vaddr_i,
    output logic              walk_resp_valid_o,
    input  logic              walk_resp_ready_i,
    output logic [PPN_W-1:0]  walk_ppn_o,
    output logic [FLAG_W-1:0] walk_flags_o,
    output logic              walk_fault_o,
    output logic              walk_level_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_resp_valid_i,
    output logic              mem_resp_ready_o,
    input  logic [ADDR_W-1:0] mem_data_i
);

    state_t             state_reg, state_next;
    logic [VPN_W-1:0]   vpn0_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [PPN_W-1:0]   ppn_reg;
    logic [FLAG_W-1:0]  flags_reg;
    logic               fault_reg;
    logic               level_reg;

    logic               pte_leaf;
    logic               pte_fault;
    logic [PPN_W-1:0]   pte_ppn;
    logic               in_l2;
    logic               pte_done;
    logic               unused_offset;

    assign unused_offset = ^walk_vaddr_i[OFF_W-1:0];
    assign in_l2         = (state_reg == L2_WAIT);
    assign pte_done      = pte_fault | pte_leaf;

    pt_walker_pte_check u_pte_check (
        .pte    (mem_data_i),
        .level2 (in_l2),
        .vpn0   (vpn0_reg),
        .leaf   (pte_leaf),
        .fault  (pte_fault),
        .ppn    (pte_ppn)
    );

    // Handshake outputs depend only on the state register, never on a ready input.
    assign walk_req_ready_o  = (state_reg == IDLE);
    assign mem_req_valid_o   = (state_reg == L1_REQ) || (state_reg == L2_REQ);
    assign mem_resp_ready_o  = (state_reg == L1_WAIT) || (state_reg == L2_WAIT);
    assign walk_resp_valid_o = (state_reg == RESP);
    assign mem_addr_o        = mem_addr_reg;
    assign walk_ppn_o        = ppn_reg;
    assign walk_flags_o      = flags_reg;
    assign walk_fault_o      = fault_reg;
    assign walk_level_o      = level_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (walk_req_valid_i)  state_next = L1_REQ;
            L1_REQ:  if (mem_req_ready_i)   state_next = L1_WAIT;
            L1_WAIT: if (mem_resp_valid_i)  state_next = pte_done ? RESP : L2_REQ;
            L2_REQ:  if (mem_req_ready_i)   state_next = L2_WAIT;
            L2_WAIT: if (mem_resp_valid_i)  state_next = RESP;
            RESP:    if (walk_resp_ready_i) state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            vpn0_reg     <= '0;
            mem_addr_reg <= '0;
            ppn_reg      <= '0;
            flags_reg    <= '0;
            fault_reg    <= 1'b0;
            level_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (walk_req_valid_i) begin
                        vpn0_reg     <= walk_vaddr_i[OFF_W +: VPN_W];
                        mem_addr_reg <= ROOT_BASE + {{(ADDR_W-VPN_W-2){1'b0}},
                                        walk_vaddr_i[ADDR_W-1 -: VPN_W], 2'b00};
                    end
                end
                L1_WAIT, L2_WAIT: begin
                    if (mem_resp_valid_i) begin
                        if (pte_done || in_l2) begin
                            ppn_reg   <= pte_ppn;
                            flags_reg <= mem_data_i[FLAG_W-1:0];
                            fault_reg <= pte_fault;
                            level_reg <= in_l2;
                        end else begin
                            // Pointer PTE: next table base plus VPN0 word index.
                            mem_addr_reg <= {mem_data_i[31:10], 10'b0}
                                          + {{(ADDR_W-VPN_W-2){1'b0}}, vpn0_reg, 2'b00};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pt_walker.sv
// Scoreboard bench for pt_walker: a small memory responder checks PTE
// addresses, a response monitor pops expected walk results.
module tb_pt_walker;

    logic        clk = 1'b0;
    logic        rst;
    logic        walk_req_valid_i;
    logic        walk_req_ready_o;
    logic [31:0] walk_vaddr_i;
    logic        walk_resp_valid_o;
    logic        walk_resp_ready_i;
    logic [19:0] walk_ppn_o;
    logic [3:0]  walk_flags_o;
    logic        walk_fault_o;
    logic        walk_level_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_resp_valid_i;
    logic        mem_resp_ready_o;
    logic [31:0] mem_data_i;

    typedef struct {
        logic [19:0] ppn;
        logic [3:0]  flags;
        logic        fault;
        logic        level;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          checks    = 0;
    int          failures  = 0;
    int          done_cnt  = 0;
    int          req_stall = 0;
    int          resp_stall = 0;

    always #5 clk = ~clk;

    pt_walker dut (
        .clk               (clk),
        .rst               (rst),
        .walk_req_valid_i  (walk_req_valid_i),
        .walk_req_ready_o  (walk_req_ready_o),
        .walk_vaddr_i      (walk_vaddr_i),
        .walk_resp_valid_o (walk_resp_valid_o),
        .walk_resp_ready_i (walk_resp_ready_i),
        .walk_ppn_o        (walk_ppn_o),
        .walk_flags_o      (walk_flags_o),
        .walk_fault_o      (walk_fault_o),
        .walk_level_o      (walk_level_o),
        .mem_req_valid_o   (mem_req_valid_o),
        .mem_req_ready_i   (mem_req_ready_i),
        .mem_addr_o        (mem_addr_o),
        .mem_resp_valid_i  (mem_resp_valid_i),
        .mem_resp_ready_o  (mem_resp_ready_o),
        .mem_data_i        (mem_data_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h400: return 32'h0000_0801;
            32'h404: return 32'h1234_0000;
            32'h408: return 32'h0C00_000B;   // aligned superpage
            32'h40C: return 32'h0C00_100B;   // misaligned superpage
            32'h800: return 32'h1000_000F;
            32'h804: return 32'h1100_000F;
            32'h808: return 32'h1200_0003;
            32'h80C: return 32'h0000_0000;
            32'h810: return 32'h1300_0005;   // W without R
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Zero-wait memory: answers the cycle after each accepted request.
    initial begin : mem_model
        logic        req_fire, resp_fire, hold_valid;
        logic [31:0] a, held, exp_a;
        mem_req_ready_i  = 1'b1;
        mem_resp_valid_i = 1'b0;
        mem_data_i       = '0;
        hold_valid       = 1'b0;
        held             = '0;
        forever begin
            @(negedge clk);
            req_fire  = mem_req_valid_o && mem_req_ready_i;
            resp_fire = mem_resp_valid_i && mem_resp_ready_o;
            a         = mem_addr_o;
            if (mem_req_valid_o && !mem_req_ready_i) begin
                if (hold_valid) chk("mem_addr_hold", a, held);
                held       = a;
                hold_valid = 1'b1;
            end else begin
                hold_valid = 1'b0;
            end
            if (req_fire && !rst) begin
                chk("mem_req_expected", (addr_q.size() > 0), 1);
                if (addr_q.size() > 0) begin
                    exp_a = addr_q.pop_front();
                    chk("mem_addr", a, exp_a);
                end
            end
            @(posedge clk); #1;
            if (resp_fire || rst) mem_resp_valid_i = 1'b0;
            if (req_fire && !rst) begin
                mem_resp_valid_i = 1'b1;
                mem_data_i       = mem_rd(a);
            end
            mem_req_ready_i = (req_stall == 0);
            if (req_stall > 0 && mem_req_valid_o) req_stall--;
        end
    end

    initial begin : resp_monitor
        logic        hold_valid;
        logic [31:0] held, cur;
        exp_t        e;
        walk_resp_ready_i = 1'b1;
        hold_valid        = 1'b0;
        held              = '0;
        forever begin
            @(negedge clk);
            cur = {6'b0, walk_ppn_o, walk_flags_o, walk_fault_o, walk_level_o};
            if (walk_resp_valid_o) begin
                if (walk_resp_ready_i) begin
                    chk("resp_expected", (exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("ppn", walk_ppn_o, e.ppn);
                        chk("flags", walk_flags_o, e.flags);
                        chk("fault", walk_fault_o, e.fault);
                        if (!e.fault) chk("level", walk_level_o, e.level);
                    end
                    $display("walk done ppn=0x%05h flags=0x%h fault=%0d level=%0d",
                             walk_ppn_o, walk_flags_o, walk_fault_o, walk_level_o);
                    done_cnt++;
                    hold_valid = 1'b0;
                end else begin
                    if (hold_valid) chk("resp_hold", cur, held);
                    held       = cur;
                    hold_valid = 1'b1;
                end
            end
            @(posedge clk); #1;
            walk_resp_ready_i = (resp_stall == 0);
            if (resp_stall > 0 && walk_resp_valid_o) resp_stall--;
        end
    end

    task automatic do_walk(input logic [31:0] va, input logic [19:0] ppn,
                           input logic [3:0] flags, input logic fault, input logic level,
                           input logic [31:0] a1, input logic [31:0] a2, input bit two,
                           input int lat);
        int   start, cyc;
        exp_t e;
        e.ppn = ppn; e.flags = flags; e.fault = fault; e.level = level;
        exp_q.push_back(e);
        addr_q.push_back(a1);
        if (two) addr_q.push_back(a2);
        start            = done_cnt;
        walk_vaddr_i     = va;
        walk_req_valid_i = 1'b1;
        cyc = 0;
        while (!walk_req_ready_o && cyc < 50) begin @(posedge clk); #1; cyc++; end
        chk("req_accept", walk_req_ready_o, 1);
        @(posedge clk); #1;
        walk_req_valid_i = 1'b0;
        cyc = 1;
        while (!walk_resp_valid_o && cyc < 200) begin @(posedge clk); #1; cyc++; end
        if (lat > 0) chk("latency", cyc, lat);
        cyc = 0;
        while (done_cnt == start && cyc < 100) begin @(posedge clk); #1; cyc++; end
        chk("walk_done", (done_cnt != start), 1);
        $display("walk va=0x%08h issued", va);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int cnt, cyc;
        rst              = 1'b1;
        walk_req_valid_i = 1'b0;
        walk_vaddr_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", walk_req_ready_o, 1);
        chk("rst_resp_valid", walk_resp_valid_o, 0);
        chk("rst_mem_req_valid", mem_req_valid_o, 0);
        chk("rst_mem_resp_ready", mem_resp_ready_o, 0);
        chk("rst_outputs", {walk_ppn_o, walk_flags_o, walk_fault_o, walk_level_o}, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_walk(32'h0000_0000, 20'h10000, 4'hF, 1'b0, 1'b1, 32'h400, 32'h800, 1, 5);
        do_walk(32'h0000_1ABC, 20'h11000, 4'hF, 1'b0, 1'b1, 32'h400, 32'h804, 1, 5);
        do_walk(32'h0000_2000, 20'h12000, 4'h3, 1'b0, 1'b1, 32'h400, 32'h808, 1, 0);
        do_walk(32'h0000_3000, 20'h00000, 4'h0, 1'b1, 1'b1, 32'h400, 32'h80C, 1, 0);
        do_walk(32'h0040_0000, 20'h00000, 4'h0, 1'b1, 1'b0, 32'h404, 32'h0,   0, 3);
        do_walk(32'h0080_5000, 20'h0C005, 4'hB, 1'b0, 1'b0, 32'h408, 32'h0,   0, 3);
        do_walk(32'h00C0_0000, 20'h00000, 4'hB, 1'b1, 1'b0, 32'h40C, 32'h0,   0, 0);
        do_walk(32'h0000_4000, 20'h00000, 4'h5, 1'b1, 1'b1, 32'h400, 32'h810, 1, 0);

        req_stall  = 5;
        resp_stall = 3;
        do_walk(32'h0000_0000, 20'h10000, 4'hF, 1'b0, 1'b1, 32'h400, 32'h800, 1, 0);

        // Abort a walk with reset while the level-2 read is outstanding.
        addr_q.push_back(32'h400);
        addr_q.push_back(32'h800);
        walk_vaddr_i     = 32'h0000_0000;
        walk_req_valid_i = 1'b1;
        @(posedge clk); #1;
        walk_req_valid_i = 1'b0;
        cnt = 0;
        cyc = 0;
        while (cnt < 2 && cyc < 50) begin
            @(negedge clk);
            if (mem_resp_ready_o) cnt++;
            cyc++;
        end
        chk("reached_l2_wait", cnt, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_req_ready", walk_req_ready_o, 1);
        chk("midrst_valids", {walk_resp_valid_o, mem_req_valid_o, mem_resp_ready_o}, 0);
        chk("midrst_outputs", {walk_ppn_o, walk_flags_o, walk_fault_o, walk_level_o}, 0);
        chk("midrst_mem_addr", mem_addr_o, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        do_walk(32'h0000_0000, 20'h10000, 4'hF, 1'b0, 1'b1, 32'h400, 32'h800, 1, 5);

        repeat (3) @(posedge clk);
        #1;
        chk("addr_q_empty", addr_q.size(), 0);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
